ddr3_app_arbiter: RTL
=====================

Name: ddr3_app_arbiter

Overview:
Two-requester arbiter and sequencer for the DDR3 controller user interface (cmd/addr/wr_data/rd_data, 256-bit app data, 29-bit app address).
- Grants one requester at a time, round-robin.
- Drives the command phase, then the write-data phase.
- Returns read data to the requester that issued the read, using an in-order tag FIFO.
- Sits between the test and traffic generators and the DDR3 memory interface, in the clk_out (clk_x1) domain.

Parameters:
ADDR_W, 29, app address width
DATA_W, 256, app data width
MASK_W, 32, write mask width (DATA_W/8)
RD_DEPTH, 8, max outstanding reads (tag FIFO depth, power of 2)

Ports:
clk  in  1  controller user clock (clk_x1)
rst_n  in  1  asynchronous active-low reset
init_calib_complete  in  1  controller calibration done
p0_req, p1_req  in  1 each  request; held with fields stable until ack
p0_cmd, p1_cmd  in  3 each  3'b000 write, 3'b001 read
p0_addr, p1_addr  in  ADDR_W each  request address
p0_wdata, p1_wdata  in  DATA_W each  write data
p0_wmask, p1_wmask  in  MASK_W each  write mask
p0_ack, p1_ack  out  1 each  one-cycle pulse: request fully accepted
p0_rvalid, p1_rvalid  out  1 each  read data valid for this port
p0_rdata, p1_rdata  out  DATA_W each  read data
app_rdy  in  1  cmd_ready
app_en  out  1  cmd_en
app_cmd  out  3  cmd
app_addr  out  ADDR_W  addr
wr_data_rdy  in  1  write data ready
app_wdf_wren  out  1  wr_data_en
app_wdf_end  out  1  wr_data_end
app_wdf_data  out  DATA_W  wr_data
app_wdf_mask  out  MASK_W  wr_data_mask
app_burst  out  1  burst; constant 0
app_rd_data_valid  in  1  rd_data_valid
app_rd_data  in  DATA_W  rd_data
rd_orphan  out  1  sticky error: read data arrived with tag FIFO empty

Behaviour:
Reset values:
- All outputs 0.
- State IDLE.
- Tag FIFO empty.
- last_grant=1, so port 0 wins the first tie.

FSM:
- IDLE
  - A request is eligible when req=1 and (cmd is write, or tag FIFO not full).
  - Requires init_calib_complete=1, sampled in IDLE only; CMD and WDATA complete regardless.
  - If both ports are eligible, grant the port != last_grant.
  - On grant: latch cmd/addr/wdata/wmask/port into registers, update last_grant, go to CMD.
- CMD
  - app_en=1; app_cmd and app_addr from the latched registers.
  - On app_rdy=1 with a write: go to WDATA.
  - On app_rdy=1 with a read: push port id into the tag FIFO, pulse ack[port] in the same cycle, go to IDLE.
- WDATA
  - app_wdf_wren=1, app_wdf_end=1; app_wdf_data and app_wdf_mask from the latched registers.
  - On wr_data_rdy=1: pulse ack[port], go to IDLE.
- Minimum cost per transaction:
  - Read: 2 cycles (IDLE, CMD).
  - Write: 3 cycles (IDLE, CMD, WDATA).
- The same port may be granted back-to-back only if the other port is not eligible.

Read return:
- On app_rd_data_valid=1: pop the FIFO head.
- Next cycle: p<head>_rvalid=1 and p<head>_rdata=app_rd_data (registered, latency 1).
- The non-selected port's rvalid is 0; its rdata holds its previous value.
- Push and pop in the same cycle are both performed; count is unchanged.
- FIFO full: reads are not granted; writes still proceed.
- app_rd_data_valid with FIFO empty: no rvalid is generated and rd_orphan sets. It clears only on reset.

Invariants and reset:
- Ack is never asserted without a preceding grant. Never two acks in one cycle.
- Asynchronous reset mid-transaction aborts immediately; outstanding tags are discarded.

Test Plan:
- Calibration gating: init_calib_complete=0, p0_req write addr 0x100 → no app_en for 20 cycles. Raise calibration → app_en next cycle, app_addr=0x100, app_cmd=0. After app_rdy, app_wdf_wren with data. p0_ack one pulse after wr_data_rdy.
- Round-robin: p0 and p1 both request writes continuously with app_rdy and wr_data_rdy held 1 → grants alternate p0, p1, p0, p1. Each write takes 3 cycles; ack counts equal after 12 transactions.
- Read routing: p0 reads 0x10, p1 reads 0x20, p0 reads 0x30. Return valid with data A, B, C → p0 gets A then C, p1 gets B. Each rvalid appears 1 cycle after app_rd_data_valid.
- Full FIFO: 8 p1 reads with no returns → the 9th p1 read is stalled while a p0 write is granted. One return → the 9th read is issued.
- Back-pressure: app_rdy low 5 cycles, then wr_data_rdy low 3 cycles → app_en held 6 cycles and wren held 4, with app_addr and app_wdf_data stable throughout.
- Orphan and reset: app_rd_data_valid with FIFO empty → rd_orphan=1, no rvalid. Assert rst_n=0 during CMD → all outputs 0 immediately, rd_orphan cleared.

Source files
------------

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: round-robin two-port arbiter/sequencer for the DDR3 app UI.
// Ports: p0_*/p1_* requester side, app_* controller side, rd_orphan sticky error.
module ddr3_app_arbiter #(
  parameter int ADDR_W   = 29,
  parameter int DATA_W   = 256,
  parameter int MASK_W   = 32,
  parameter int RD_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              p0_req,
  input  logic [2:0]        p0_cmd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [MASK_W-1:0] p0_wmask,
  output logic              p0_ack,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [2:0]        p1_cmd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [MASK_W-1:0] p1_wmask,
  output logic              p1_ack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              wr_data_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_burst,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data,
  output logic              rd_orphan
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          cur_port;
  logic          cur_wr;

  logic          tag_mem [RD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic rd0, rd1;
  logic el0, el1;
  logic pick;
  logic full, empty;
  logic push, pop;
  logic head;

  assign app_burst = 1'b0;

  assign full  = (count == CW'(RD_DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  assign rd0 = (p0_cmd == 3'b001);
  assign rd1 = (p1_cmd == 3'b001);

  // A port whose ack is showing still holds req this cycle; mask it so the
  // same request is not granted twice.
  assign el0 = p0_req & ~p0_ack & (~rd0 | ~full);
  assign el1 = p1_req & ~p1_ack & (~rd1 | ~full);

  assign pick = (el0 & el1) ? ~last_grant : el1;

  assign push = (state == CMD) & app_rdy & ~cur_wr;
  assign pop  = app_rd_data_valid & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cur_port     <= 1'b0;
      cur_wr       <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= '0;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (init_calib_complete && (el0 || el1)) begin
            cur_port     <= pick;
            last_grant   <= pick;
            cur_wr       <= pick ? ~rd1 : ~rd0;
            app_cmd      <= pick ? p1_cmd : p0_cmd;
            app_addr     <= pick ? p1_addr : p0_addr;
            app_wdf_data <= pick ? p1_wdata : p0_wdata;
            app_wdf_mask <= pick ? p1_wmask : p0_wmask;
            app_en       <= 1'b1;
            state        <= CMD;
          end
        end
        CMD: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            if (cur_wr) begin
              app_wdf_wren <= 1'b1;
              app_wdf_end  <= 1'b1;
              state        <= WDATA;
            end else begin
              p0_ack <= ~cur_port;
              p1_ack <= cur_port;
              state  <= IDLE;
            end
          end
        end
        WDATA: begin
          if (wr_data_rdy) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            p0_ack       <= ~cur_port;
            p1_ack       <= cur_port;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cur_port;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      rd_orphan <= 1'b0;
    end else begin
      p0_rvalid <= pop & ~head;
      p1_rvalid <= pop & head;
      if (pop && !head) p0_rdata <= app_rd_data;
      if (pop && head)  p1_rdata <= app_rd_data;
      if (app_rd_data_valid && empty) rd_orphan <= 1'b1;
    end
  end

endmodule
